// File: rtl/half_adder.sv
// Half adder bit cell: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock via two half_adder cells.
// Define BIT_SERIAL_ADDER_SUB_EN to add the sub port (A - B via inverted B and carry-in of 1).
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_n_s;
  logic [WIDTH-1:0] a_sh_r, a_sh_n_s;
  logic [WIDTH-1:0] b_sh_r, b_sh_n_s;
  logic [WIDTH-1:0] res_sh_r, res_sh_n_s;
  logic [WIDTH-1:0] res_shift_s;
  logic [WIDTH-1:0] s_msb_s;
  logic             carry_r, carry_n_s;
  logic [CW-1:0]    cnt_r, cnt_n_s;
  logic [WIDTH-1:0] sum_out_r, sum_out_n_s;
  logic             carry_out_r, carry_out_n_s;
  logic             carry_init_s;
  logic             b_bit_s;
  logic             s1_s, c1_s, s_s, c2_s, c_next_s;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic sub_r, sub_n_s;
  assign b_bit_s      = b_sh_r[0] ^ sub_r;
  assign carry_init_s = sub;
`else
  assign b_bit_s      = b_sh_r[0];
  assign carry_init_s = 1'b0;
`endif

  half_adder u_ha0 (.a(a_sh_r[0]), .b(b_bit_s), .s(s1_s), .c(c1_s));
  half_adder u_ha1 (.a(s1_s),      .b(carry_r), .s(s_s),  .c(c2_s));

  assign c_next_s = c1_s | c2_s;

  // Result register after this cycle's sum bit enters at the MSB (WIDTH=1 safe).
  always_comb begin
    s_msb_s            = '0;
    s_msb_s[WIDTH-1]   = s_s;
    res_shift_s        = (res_sh_r >> 1) | s_msb_s;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_n_s     = state_r;
    a_sh_n_s      = a_sh_r;
    b_sh_n_s      = b_sh_r;
    res_sh_n_s    = res_sh_r;
    carry_n_s     = carry_r;
    cnt_n_s       = cnt_r;
    sum_out_n_s   = sum_out_r;
    carry_out_n_s = carry_out_r;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    sub_n_s       = sub_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          a_sh_n_s   = a_in;
          b_sh_n_s   = b_in;
          res_sh_n_s = '0;
          carry_n_s  = carry_init_s;
          cnt_n_s    = '0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
          sub_n_s    = sub;
`endif
          state_n_s  = RUN;
        end else begin
          state_n_s  = IDLE;
        end
      end
      RUN: begin
        a_sh_n_s   = a_sh_r >> 1;
        b_sh_n_s   = b_sh_r >> 1;
        res_sh_n_s = res_shift_s;
        carry_n_s  = c_next_s;
        cnt_n_s    = cnt_r + CW'(1);
        if (cnt_r == LAST_CNT) begin
          // Outputs only change here, on the edge that enters DONE.
          sum_out_n_s   = res_shift_s;
          carry_out_n_s = c_next_s;
          state_n_s     = DONE;
        end else begin
          state_n_s     = RUN;
        end
      end
      DONE: begin
        state_n_s = IDLE;
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      res_sh_r    <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_out_r   <= '0;
      carry_out_r <= 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_n_s;
      a_sh_r      <= a_sh_n_s;
      b_sh_r      <= b_sh_n_s;
      res_sh_r    <= res_sh_n_s;
      carry_r     <= carry_n_s;
      cnt_r       <= cnt_n_s;
      sum_out_r   <= sum_out_n_s;
      carry_out_r <= carry_out_n_s;
`ifdef BIT_SERIAL_ADDER_SUB_EN
      sub_r       <= sub_n_s;
`endif
    end
  end

  assign busy      = (state_r == RUN);
  assign done      = (state_r == DONE);
  assign sum_out   = sum_out_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8); subtract cases
// run only when BIT_SERIAL_ADDER_SUB_EN is defined.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       carry_out;

  int checks_s;
  int failures_s;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Count negedges after the accepting edge until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_sum, input logic exp_c);
    int n;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    check({tag, "_latency"}, n, 32'd8);
    check({tag, "_sum"}, {24'd0, sum_out}, {24'd0, exp_sum});
    check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    checks_s   = 0;
    failures_s = 0;
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h12;
    b_in  = 8'h34;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum_out}, 32'h00);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("rst_no_start", {31'd0, busy}, 32'd0);

    do_op("add_3c_05", 8'h3C, 8'h05, 8'h41, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // start held through RUN/DONE is ignored until IDLE at edge 10
    @(negedge clk);
    a_in  = 8'h10;
    b_in  = 8'h20;
    start = 1'b1;
    @(negedge clk);
    a_in  = 8'hAA;
    b_in  = 8'h55;
    wait_done(n);
    check("hold_first_latency", n, 32'd8);
    check("hold_first_sum", {24'd0, sum_out}, 32'h30);
    check("hold_first_carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    check("hold_edge9_busy", {31'd0, busy}, 32'd0);
    check("hold_edge9_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("hold_edge10_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(n);
    check("hold_second_latency", n, 32'd8);
    check("hold_second_sum", {24'd0, sum_out}, 32'hFF);
    check("hold_second_carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);

    // Reset sampled at the 4th RUN edge aborts the op
    @(negedge clk);
    a_in  = 8'h3C;
    b_in  = 8'h05;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum_out}, 32'h00);
    check("abort_carry", {31'd0, carry_out}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", pulses, 32'd0);
    do_op("after_abort", 8'h01, 8'h02, 8'h03, 1'b0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op("sub_07_05", 8'h07, 8'h05, 8'h02, 1'b1);
    do_op("sub_05_07", 8'h05, 8'h07, 8'hFE, 1'b0);
    do_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b1);
    sub = 1'b0;
    do_op("sub0_add", 8'h3C, 8'h05, 8'h41, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
